// File: rtl/fft_pkg.sv
// fft_pkg: shared state type and width helper for the magnitude square-root unit
package fft_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;
  function automatic int root_w(input int sample_size);
    return sample_size / 2;
  endfunction
endpackage

// File: rtl/fft_mag_sqrt_unit_isqrt_step.sv
// isqrt_step: one combinational digit-by-digit square-root iteration
module isqrt_step
  import fft_pkg::*;
#(
  parameter int sample_size = 32,
  localparam int rw = root_w(sample_size)
) (
  input  logic [rw+1:0] rem_in,
  input  logic [rw-1:0] root_in,
  input  logic [1:0]    pair,
  output logic [rw+1:0] rem_out,
  output logic [rw-1:0] root_out
);
  logic [rw+1:0] rem_sh;
  logic [rw+1:0] trial;
  logic          ge;
  always_comb begin
    rem_sh   = {rem_in[rw-1:0], pair};
    trial    = {root_in, 2'b01};
    ge       = rem_sh >= trial;
    rem_out  = ge ? rem_sh - trial : rem_sh;
    root_out = {root_in[rw-2:0], ge};
  end
endmodule

// File: rtl/fft_mag_sqrt_unit.sv
// fft_mag_sqrt_unit: iterative floor(sqrt) of every lane of a packed squared-magnitude bus
module fft_mag_sqrt_unit
  import fft_pkg::*;
#(
  parameter int sample_size = 32,
  parameter int buffer_size = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [buffer_size*sample_size-1:0] in_mags,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [buffer_size*sample_size-1:0] out_mags,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);
  localparam int rw = root_w(sample_size);
  localparam int bw = buffer_size * sample_size;
  localparam int cw = $clog2(rw + 1);
  localparam int iw = $clog2(buffer_size + 1);
  sqrt_state_t      state_q, state_d;
  logic [bw-1:0]    buf_q, buf_d;
  logic [bw-1:0]    res_q, res_d;
  logic [iw-1:0]    idx_q, idx_d;
  logic [rw+1:0]    rem_q, rem_d;
  logic [rw-1:0]    root_q, root_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [sample_size-1:0] lane;
  logic [1:0]       pair;
  logic [rw+1:0]    rem_nx;
  logic [rw-1:0]    root_nx;
  assign lane = buf_q[idx_q*sample_size +: sample_size];
  assign pair = lane[2*cnt_q +: 2];
  isqrt_step #(.sample_size(sample_size)) u_step (
    .rem_in  (rem_q),
    .root_in (root_q),
    .pair    (pair),
    .rem_out (rem_nx),
    .root_out(root_nx)
  );
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    res_d   = res_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      buf_d   = in_mags;
      idx_d   = '0;
      rem_d   = '0;
      root_d  = '0;
      cnt_d   = cw'(rw - 1);
      state_d = CALC;
    end else if (state_q == CALC) begin
      rem_d  = rem_nx;
      root_d = root_nx;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        res_d[idx_q*sample_size +: sample_size] = {{(sample_size-rw){1'b0}}, root_nx};
        if (idx_q == iw'(buffer_size - 1)) begin
          state_d = DONE;
        end else begin
          idx_d  = idx_q + 1'b1;
          rem_d  = '0;
          root_d = '0;
          cnt_d  = cw'(rw - 1);
        end
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
    busy_d      = state_d == CALC;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_mags  = res_q;
endmodule

// File: tb/tb_fft_mag_sqrt_unit.sv
// tb_fft_mag_sqrt_unit: scoreboard bench for the packed-lane integer square-root unit
module tb_fft_mag_sqrt_unit;
  localparam int ss = 32;
  localparam int bs = 4;
  localparam int bw = ss * bs;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [bw-1:0] in_mags = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [bw-1:0] out_mags;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  int            asserts = 0;
  int            fails = 0;
  logic [bw-1:0] sb[$];
  fft_mag_sqrt_unit #(.sample_size(ss), .buffer_size(bs)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_mags  (in_mags),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_mags (out_mags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  function automatic longint exp_sqrt(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  function automatic logic [bw-1:0] model(input logic [bw-1:0] b);
    logic [bw-1:0] m;
    for (int i = 0; i < bs; i++) m[i*ss +: ss] = ss'(exp_sqrt(longint'(b[i*ss +: ss])));
    return m;
  endfunction
  function automatic logic [ss-1:0] rand_lane();
    logic [ss-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin v = $urandom_range(0, 65535); v = v * v; end
      2: begin v = $urandom_range(1, 65535); v = v * v - 1; end
      default: v = $urandom_range(0, 1000);
    endcase
    return v;
  endfunction
  function automatic logic [bw-1:0] pop_exp();
    return sb.size() != 0 ? sb.pop_front() : 'x;
  endfunction
  task automatic accept(input logic [bw-1:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_mags = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back(model(b));
  endtask
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    asserts++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy});
    end
    asserts++;
    if (out_mags !== '0) begin
      fails++;
      $display("FAIL reset_out_mags: got %h expected 0", out_mags);
    end
    reset = 1'b0;
  endtask
  task automatic test_basic();
    logic [bw-1:0] e;
    logic [bw-1:0] k;
    int cyc;
    k = {32'd7, 32'd8, 32'd9, 32'd10};
    accept({32'd58, 32'd68, 32'd82, 32'd100});
    asserts++;
    if ({busy, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL basic_busy: got %b expected 10", {busy, in_ready});
    end
    wait_out(cyc);
    asserts++;
    if (cyc != 64) begin
      fails++;
      $display("FAIL basic_latency: got %0d expected 64", cyc);
    end
    e = pop_exp();
    asserts++;
    if (out_mags !== e) begin
      fails++;
      $display("FAIL basic_model: got %h expected %h", out_mags, e);
    end
    asserts++;
    if (out_mags !== k) begin
      fails++;
      $display("FAIL basic_const: got %h expected %h", out_mags, k);
    end
    asserts++;
    if ({busy, in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL basic_done_flags: got %b expected 00", {busy, in_ready});
    end
    release_out();
    asserts++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL basic_single_xfer: got %b expected 01", {out_valid, in_ready});
    end
  endtask
  task automatic test_boundaries();
    logic [bw-1:0] e;
    logic [bw-1:0] k;
    int cyc;
    k = {32'd32768, 32'd65535, 32'd1, 32'd0};
    accept({32'h40000000, 32'hFFFFFFFF, 32'd1, 32'd0});
    wait_out(cyc);
    e = pop_exp();
    asserts++;
    if (out_mags !== k || out_mags !== e) begin
      fails++;
      $display("FAIL bound_values: got %h expected %h (model %h)", out_mags, k, e);
    end
    for (int i = 0; i < bs; i++) begin
      asserts++;
      if (out_mags[i*ss+ss/2 +: ss/2] !== '0) begin
        fails++;
        $display("FAIL bound_upper_lane%0d: got %h expected 0", i, out_mags[i*ss+ss/2 +: ss/2]);
      end
    end
    release_out();
  endtask
  task automatic test_chain_random();
    logic [bw-1:0] b;
    logic [bw-1:0] e;
    logic [ss-1:0] re;
    logic [ss-1:0] im;
    int cyc;
    re = 3;
    im = 4;
    accept({rand_lane(), rand_lane(), rand_lane(), re * re + im * im});
    wait_out(cyc);
    e = pop_exp();
    asserts++;
    if (out_mags[ss-1:0] !== 32'd5 || out_mags !== e) begin
      fails++;
      $display("FAIL chain_3_4: got %h expected lane0 5 (model %h)", out_mags, e);
    end
    release_out();
    for (int n = 0; n < 250; n++) begin
      for (int i = 0; i < bs; i++) b[i*ss +: ss] = rand_lane();
      accept(b);
      wait_out(cyc);
      e = pop_exp();
      for (int i = 0; i < bs; i++) begin
        asserts++;
        if (out_mags[i*ss +: ss] !== e[i*ss +: ss]) begin
          fails++;
          $display("FAIL random_lane: in %h got %h expected %h", b[i*ss +: ss], out_mags[i*ss +: ss], e[i*ss +: ss]);
        end
      end
      release_out();
    end
  endtask
  task automatic test_backpressure();
    logic [bw-1:0] b;
    logic [bw-1:0] e;
    logic [bw-1:0] save;
    int cyc;
    for (int i = 0; i < bs; i++) b[i*ss +: ss] = rand_lane();
    accept(b);
    wait_out(cyc);
    e = pop_exp();
    asserts++;
    if (out_mags !== e) begin
      fails++;
      $display("FAIL bp_result: got %h expected %h", out_mags, e);
    end
    save = e;
    in_mags = ~b;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      asserts++;
      if ({out_valid, in_ready, busy, out_mags} !== {3'b100, save}) begin
        fails++;
        $display("FAIL bp_hold_%0d: got %b/%h expected 100/%h", c, {out_valid, in_ready, busy}, out_mags, save);
      end
    end
    in_valid = 1'b0;
    release_out();
    asserts++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL bp_release: got %b expected 010", {out_valid, in_ready, busy});
    end
  endtask
  task automatic test_input_change();
    logic [bw-1:0] b;
    logic [bw-1:0] e;
    int cyc;
    for (int i = 0; i < bs; i++) b[i*ss +: ss] = rand_lane();
    in_mags = b;
    in_valid = 1'b1;
    @(negedge clk);
    sb.push_back(model(b));
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      asserts++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL chg_in_ready_%0d: got %b expected 0", cyc, in_ready);
      end
      for (int i = 0; i < bs; i++) in_mags[i*ss +: ss] = $urandom;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    e = pop_exp();
    asserts++;
    if (cyc != 64 || out_mags !== e) begin
      fails++;
      $display("FAIL chg_result: got %h after %0d cycles expected %h after 64", out_mags, cyc, e);
    end
    release_out();
  endtask
  task automatic test_mid_reset();
    logic [bw-1:0] b;
    logic [bw-1:0] e;
    int cyc;
    for (int i = 0; i < bs; i++) b[i*ss +: ss] = rand_lane() | 32'h100;
    accept(b);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    asserts++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL rst_mid_flags: got %b expected 010", {out_valid, in_ready, busy});
    end
    asserts++;
    if (out_mags !== '0) begin
      fails++;
      $display("FAIL rst_mid_out_mags: got %h expected 0", out_mags);
    end
    for (int i = 0; i < bs; i++) b[i*ss +: ss] = rand_lane();
    accept(b);
    wait_out(cyc);
    e = pop_exp();
    asserts++;
    if (cyc != 64 || out_mags !== e) begin
      fails++;
      $display("FAIL rst_fresh: got %h after %0d cycles expected %h after 64", out_mags, cyc, e);
    end
    release_out();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_chain_random();
    test_backpressure();
    test_input_change();
    test_mid_reset();
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
